// File: rtl/display_scan_sequencer_if.sv
// Register-file to scan-sequencer bundle: timing/pattern configuration in,
// multiplexed digit/segment drive and status pulses out.
interface display_scan_sequencer_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned BLANK_W    = 8
);
  logic                        cfg_enable;
  logic [DWELL_W-1:0]          cfg_dwell;
  logic [BLANK_W-1:0]          cfg_blank;
  logic [NUM_DIGITS*SEG_W-1:0] digit_data;
  logic                        update_req;
  logic [NUM_DIGITS-1:0]       digit_sel;
  logic [SEG_W-1:0]            seg_out;
  logic                        frame_done;
  logic                        update_ack;
  logic                        busy;

  modport master (
    output cfg_enable, cfg_dwell, cfg_blank, digit_data, update_req,
    input  digit_sel, seg_out, frame_done, update_ack, busy
  );

  modport slave (
    input  cfg_enable, cfg_dwell, cfg_blank, digit_data, update_req,
    output digit_sel, seg_out, frame_done, update_ack, busy
  );
endinterface

// File: rtl/display_scan_sequencer.sv
// Time-multiplexed display scan controller: latches patterns/timing at each
// frame start, lights one digit per dwell window with an optional blank gap.
module display_scan_sequencer #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SEG_W      = 8,
  parameter int unsigned DWELL_W    = 16,
  parameter int unsigned BLANK_W    = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  display_scan_sequencer_if.slave   bus
);

  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned CNT_W = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_DISPLAY = 2'd2,
    S_BLANK   = 2'd3
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [CNT_W-1:0]    r_cnt;
  logic [SEG_W-1:0]    r_shadow [NUM_DIGITS];
  logic [DWELL_W-1:0]  r_dwell_lat;
  logic [BLANK_W-1:0]  r_blank_lat;
  logic                r_pending;
  logic [NUM_DIGITS-1:0] r_digit_sel;
  logic [SEG_W-1:0]    r_seg_out;
  logic                r_frame_done;
  logic                r_update_ack;
  logic                r_busy;

  logic [DWELL_W-1:0]  w_dwell_cfg;
  logic [IDX_W-1:0]    w_idx_nxt;
  logic                w_last;
  logic                w_advance;

  // A zero dwell would never light the digit, so it is promoted to one cycle.
  assign w_dwell_cfg = (bus.cfg_dwell == '0) ? DWELL_W'(1) : bus.cfg_dwell;
  assign w_idx_nxt   = r_idx + IDX_W'(1);
  assign w_last      = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_advance   = (r_cnt == '0) &&
                       (((r_state == S_DISPLAY) && (r_blank_lat == '0)) ||
                        (r_state == S_BLANK));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_cnt        <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) r_shadow[i] <= '0;
      r_dwell_lat  <= '0;
      r_blank_lat  <= '0;
      r_pending    <= 1'b0;
      r_digit_sel  <= '0;
      r_seg_out    <= '0;
      r_frame_done <= 1'b0;
      r_update_ack <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_update_ack <= 1'b0;
      if (bus.update_req) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (bus.cfg_enable) begin
            r_state <= S_LOAD;
            r_busy  <= 1'b1;
          end
        end
        S_LOAD: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            r_shadow[i] <= bus.digit_data[i*SEG_W +: SEG_W];
          r_dwell_lat  <= w_dwell_cfg;
          r_blank_lat  <= bus.cfg_blank;
          r_idx        <= '0;
          r_update_ack <= r_pending | bus.update_req;
          r_pending    <= 1'b0;
          r_cnt        <= CNT_W'(w_dwell_cfg - DWELL_W'(1));
          r_state      <= S_DISPLAY;
          r_digit_sel  <= NUM_DIGITS'(1);
          r_seg_out    <= bus.digit_data[0 +: SEG_W];
        end
        S_DISPLAY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else if (r_blank_lat != '0) begin
            r_state     <= S_BLANK;
            r_cnt       <= CNT_W'(r_blank_lat - BLANK_W'(1));
            r_digit_sel <= '0;
            r_seg_out   <= '0;
          end
        end
        S_BLANK: begin
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase

      // End of a digit slot: step to the next digit or close the frame.
      if (w_advance) begin
        if (!w_last) begin
          r_idx       <= w_idx_nxt;
          r_state     <= S_DISPLAY;
          r_cnt       <= CNT_W'(r_dwell_lat - DWELL_W'(1));
          r_digit_sel <= NUM_DIGITS'(1) << w_idx_nxt;
          r_seg_out   <= r_shadow[w_idx_nxt];
        end else begin
          r_frame_done <= 1'b1;
          r_digit_sel  <= '0;
          r_seg_out    <= '0;
          if (bus.cfg_enable) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.digit_sel  = r_digit_sel;
  assign bus.seg_out    = r_seg_out;
  assign bus.frame_done = r_frame_done;
  assign bus.update_ack = r_update_ack;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Scoreboard bench for display_scan_sequencer: a frame-level reference model
// queues expected per-cycle outputs; a negedge monitor compares them.
module tb_display_scan_sequencer;

  localparam int unsigned ND = 4;
  localparam int unsigned SW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;

  typedef struct packed {
    logic [ND-1:0] sel;
    logic [SW-1:0] seg;
    logic          fd;
    logic          ack;
    logic          busy;
  } out_t;

  bit   ACLK = 1'b0;
  logic ARESET;

  display_scan_sequencer_if #(.NUM_DIGITS(ND), .SEG_W(SW), .DWELL_W(DW), .BLANK_W(BW)) bus ();

  display_scan_sequencer #(.NUM_DIGITS(ND), .SEG_W(SW), .DWELL_W(DW), .BLANK_W(BW)) dut (
    .ACLK   (ACLK),
    .ARESET (ARESET),
    .bus    (bus)
  );

  always #5 ACLK = ~ACLK;

  int   vectors     = 0;
  int   miscompares = 0;
  int   ack_count   = 0;
  out_t exp_q  [$];
  out_t plan_q [$];
  int   m_mode = 0;   // 0 idle, 1 load, 2 frame in progress
  bit   m_pend = 1'b0;

  // Reference model: at each edge decide the output of the coming cycle.
  // A whole frame is expanded into plan_q when the load cycle samples config.
  always @(posedge ACLK) begin
    out_t o, t;
    int   d, b;
    logic ack;
    o = '0;
    if (ARESET) begin
      plan_q.delete();
      m_mode = 0;
      m_pend = 1'b0;
    end else begin
      if (bus.update_req && m_mode != 1) m_pend = 1'b1;
      case (m_mode)
        0: begin
          if (bus.cfg_enable) begin
            o.busy = 1'b1;
            m_mode = 1;
          end
        end
        1: begin
          ack    = m_pend | bus.update_req;
          m_pend = 1'b0;
          d = (bus.cfg_dwell == 0) ? 1 : int'(bus.cfg_dwell);
          b = int'(bus.cfg_blank);
          for (int k = 0; k < ND; k++) begin
            for (int c = 0; c < d; c++) begin
              t = '0;
              t.sel  = ND'(1) << k;
              t.seg  = bus.digit_data[k*SW +: SW];
              t.busy = 1'b1;
              plan_q.push_back(t);
            end
            for (int c = 0; c < b; c++) begin
              t = '0;
              t.busy = 1'b1;
              plan_q.push_back(t);
            end
          end
          plan_q[0].ack = ack;
          o = plan_q.pop_front();
          m_mode = 2;
        end
        default: begin
          if (plan_q.size() > 0) begin
            o = plan_q.pop_front();
          end else begin
            o.fd = 1'b1;
            if (bus.cfg_enable) begin
              o.busy = 1'b1;
              m_mode = 1;
            end else begin
              m_mode = 0;
            end
          end
        end
      endcase
    end
    exp_q.push_back(o);
  end

  // Monitor: one expected tuple per cycle, plus the digit exclusivity rule.
  always @(negedge ACLK) begin
    out_t e, a;
    a = {bus.digit_sel, bus.seg_out, bus.frame_done, bus.update_ack, bus.busy};
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got output sel=%b seg=%h with no expectation queued", a.sel, a.seg);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_out @%0t: got sel=%b seg=%h fd=%b ack=%b busy=%b, want sel=%b seg=%h fd=%b ack=%b busy=%b",
                 $time, a.sel, a.seg, a.fd, a.ack, a.busy, e.sel, e.seg, e.fd, e.ack, e.busy);
      end
    end
    vectors++;
    if (!$onehot0(a.sel)) begin
      miscompares++;
      $display("FAIL onehot0 @%0t: got digit_sel=%b, want at most one bit set", $time, a.sel);
    end
    if (a.ack === 1'b1) ack_count++;
  end

  task automatic wait_sel(input logic [ND-1:0] v, input int max, input string nm);
    int n = 0;
    while (bus.digit_sel !== v && n < max) begin
      @(negedge ACLK);
      n++;
    end
    vectors++;
    if (bus.digit_sel !== v) begin
      miscompares++;
      $display("FAIL %s: got digit_sel=%b after %0d cycles, want %b", nm, bus.digit_sel, n, v);
    end
  endtask

  // Steps at least one cycle, returns cycles until frame_done is seen.
  task automatic wait_fd(input int max, input string nm, output int n);
    n = 0;
    do begin
      @(negedge ACLK);
      n++;
    end while (bus.frame_done !== 1'b1 && n < max);
    vectors++;
    if (bus.frame_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s: got no frame_done within %0d cycles, want a pulse", nm, max);
    end
  endtask

  task automatic check_period(input int want, input string nm);
    int n;
    wait_fd(200, nm, n);
    wait_fd(200, nm, n);
    vectors++;
    if (n != want) begin
      miscompares++;
      $display("FAIL %s: got frame period %0d, want %0d", nm, n, want);
    end
  endtask

  initial begin
    int n, ack0;
    ARESET         = 1'b1;
    bus.cfg_enable = 1'b0;
    bus.cfg_dwell  = '0;
    bus.cfg_blank  = '0;
    bus.digit_data = '0;
    bus.update_req = 1'b0;

    repeat (10) @(negedge ACLK);
    ARESET = 1'b0;
    repeat (20) @(negedge ACLK);

    // Basic scan: 3-cycle dwell, 1-cycle blank.
    bus.cfg_dwell  = 16'd3;
    bus.cfg_blank  = 8'd1;
    bus.digit_data = 32'h3F065B4F;
    bus.cfg_enable = 1'b1;
    check_period(1 + ND * (3 + 1), "period_basic");

    // Zero dwell/blank: one lit cycle per digit, no gaps.
    bus.cfg_dwell = '0;
    bus.cfg_blank = '0;
    wait_fd(200, "fd_zero_sync", n);
    check_period(1 + ND * 1, "period_zero");

    // Mid-frame update with two request pulses during digit 1.
    bus.cfg_dwell = 16'd3;
    bus.cfg_blank = 8'd1;
    wait_fd(200, "fd_upd_sync", n);
    wait_fd(200, "fd_upd_sync2", n);
    ack0 = ack_count;
    wait_sel(4'b0010, 100, "wait_digit1");
    bus.digit_data = 32'hFFFFFFFF;
    bus.update_req = 1'b1;
    @(negedge ACLK);
    bus.update_req = 1'b0;
    @(negedge ACLK);
    bus.update_req = 1'b1;
    @(negedge ACLK);
    bus.update_req = 1'b0;
    wait_fd(200, "fd_upd_a", n);
    wait_fd(200, "fd_upd_b", n);
    vectors++;
    if (ack_count - ack0 != 1) begin
      miscompares++;
      $display("FAIL update_ack_count: got %0d acks, want 1", ack_count - ack0);
    end

    // Disable during digit 2: frame finishes, then idle.
    bus.digit_data = 32'h12345678;
    wait_sel(4'b0100, 100, "wait_digit2");
    bus.cfg_enable = 1'b0;
    wait_fd(200, "fd_disable", n);
    vectors++;
    if (bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_disable: got busy=%b, want 0", bus.busy);
    end
    repeat (5) @(negedge ACLK);
    bus.cfg_enable = 1'b1;

    // Asynchronous reset mid-display.
    wait_sel(4'b0010, 100, "wait_digit1_rst");
    #2 ARESET = 1'b1;
    #1;
    vectors++;
    if ({bus.digit_sel, bus.seg_out, bus.frame_done, bus.update_ack, bus.busy} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got sel=%b seg=%h fd=%b ack=%b busy=%b, want all 0",
               bus.digit_sel, bus.seg_out, bus.frame_done, bus.update_ack, bus.busy);
    end
    @(negedge ACLK);
    @(negedge ACLK);
    ARESET = 1'b0;

    // Randomized configuration, enable and update traffic.
    for (int i = 0; i < 10000; i++) begin
      @(negedge ACLK);
      bus.cfg_enable = ($urandom_range(0, 31) != 0);
      bus.update_req = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 19) == 0) begin
        bus.cfg_dwell  = DW'($urandom_range(0, 5));
        bus.cfg_blank  = BW'($urandom_range(0, 3));
        bus.digit_data = $urandom();
      end
    end
    bus.update_req = 1'b0;
    bus.cfg_enable = 1'b0;
    repeat (60) @(negedge ACLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
